nnrv_id: RTL and testbench
==========================

# nnrv_id

Instruction-decode stage of the nnrv RV64I pipeline, directly downstream of the fetch stage. Each cycle it takes the fetched instruction and its PC, decodes it, reads the 32x64 integer register file, and registers the decoded bundle into the execute stage. It also resolves branches and jumps and detects read-after-write hazards, driving the fetch stage's jump-redirect and hazard-stall inputs combinationally.

## Interface
- INSTR_WIDTH, 32, instruction width
- XLEN, 64, register and PC width
- REG_NUM, 32, architectural integer registers (x0 hardwired to 0)

- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_if_instr  in  INSTR_WIDTH  instruction from fetch
- i_if_cur_pc  in  XLEN  PC of i_if_instr
- o_if_jmp_stall  out  1  redirect fetch to o_if_jmp_pc (combinational)
- o_if_jmp_pc  out  XLEN  redirect target (combinational)
- o_if_hazard_stall  out  1  fetch holds cur_pc and re-presents the same instruction (combinational)
- i_mem_rd_wen  in  1  instruction in MEM will write a register
- i_mem_rd  in  5  its destination
- i_wb_en  in  1  register-file write enable
- i_wb_rd  in  5  write index
- i_wb_data  in  XLEN  write data
- o_ex_valid  out  1  EX bundle valid; 0 = bubble
- o_ex_pc  out  XLEN  instruction PC
- o_ex_opcode  out  7  instr[6:0]
- o_ex_funct3  out  3  instr[14:12]
- o_ex_funct7  out  7  instr[31:25]
- o_ex_rs1_data, o_ex_rs2_data  out  XLEN  operand values
- o_ex_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode); for JAL/JALR, pc+4 (link value)
- o_ex_rd  out  5  destination
- o_ex_rd_wen  out  1  destination write enable (0 when rd = x0)
- o_ex_illegal  out  1  unsupported opcode seen (single-cycle flag)

## Operation
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP-IMM-32, OP, OP-32. Instruction 0x00000000 is a bubble: valid=0, no flag.
- Any other opcode: valid=0 and o_ex_illegal=1 for that cycle; no jump, no stall.
- rs1 is used by all supported opcodes except LUI, AUIPC, JAL; rs2 by BRANCH, STORE, OP, OP-32. Unused or x0 sources never cause a hazard.
- Register file: x0 reads 0 and ignores writes. Write on i_clk when i_wb_en. A same-cycle read of i_wb_rd returns i_wb_data (write-through).
- Hazard: a used nonzero source matches (o_ex_valid & o_ex_rd_wen & o_ex_rd) or (i_mem_rd_wen & i_mem_rd). It asserts o_if_hazard_stall and registers a bubble into EX. The same instruction reappears next cycle and is re-evaluated.
- Jump, evaluated only when there is no hazard:
  - JAL: target = pc + immJ.
  - JALR: target = (rs1 + immI) with bit 0 cleared.
  - Taken BEQ/BNE/BLT/BGE/BLTU/BGEU: target = pc + immB. Signed and unsigned 64-bit compares.
  - Target bits [1:0] are forced to 00.
  - o_if_jmp_stall is asserted for that cycle only. The jump/branch instruction itself is issued to EX valid; branches issue with rd_wen=0.
- Not-taken branch: no jmp_stall; the instruction issues with rd_wen=0.
- o_if_jmp_stall and o_if_hazard_stall are never both 1.
- While i_rst=1, all combinational fetch-facing outputs are 0.

## Timing
- Fetch-facing outputs are purely combinational from i_if_instr, i_if_cur_pc, the register file, EX registers and the i_mem_* inputs. There are no registers on this path.
- EX bundle: registered, latency 1 cycle from the instruction being present without hazard.
- Reset (synchronous): on the i_rst clock edge, all o_ex_* outputs become 0 (valid 0, illegal 0) and all 32 registers are cleared to 0. Reset mid-stream discards the EX bundle; no writes occur during reset.
- Back-to-back dependency with no forwarding: the consumer stalls 2 cycles (producer in EX, then in MEM), then issues using the WB write-through value.
- Redirect penalty is 0 cycles: on the jmp_stall cycle, fetch already reads the target, and the target instruction arrives at ID on the next edge.

## Test plan
- Reset: pulse i_rst for 2 cycles -> o_ex_valid=0, o_ex_* = 0, fetch-facing outputs 0; reading x5 afterwards returns 0.
- ADDI x1,x0,5 at pc 0x0 -> next cycle o_ex_valid=1, o_ex_imm=5, o_ex_rd=1, rd_wen=1, pc=0.
- ADDI x1,x0,5 followed by ADD x2,x1,x1: hold i_mem_rd_wen/i_mem_rd per pipeline, then WB writes x1=5 -> hazard_stall high for exactly 2 cycles, two bubbles, then ADD issues with rs1=rs2=5.
- x3=x4=7, BEQ x3,x4,+16 at pc 0x100 -> jmp_stall=1, jmp_pc=0x110 for one cycle; the branch issues with rd_wen=0. With x4=8 -> no jmp_stall.
- JALR x1,x2,3 with x2=0x200 at pc 0x40 -> jmp_pc=0x200 (bits [1:0] cleared), o_ex_imm=0x44, rd=1.
- Opcode 0x7F -> o_ex_illegal=1 one cycle, valid=0, no stall. Write to x0 via WB -> x0 still reads 0.

Source files
------------

// File: rtl/nnrv_id.sv
// RV64I decode stage: decodes, reads the register file and resolves jumps and RAW hazards combinationally toward fetch.
// The EX bundle is registered with 1-cycle latency; a hazard stalls fetch and inserts a bubble, with no skid buffer.
module nnrv_id #(
    parameter int INSTR_WIDTH = 32,
    parameter int XLEN        = 64,
    parameter int REG_NUM     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [INSTR_WIDTH-1:0] i_if_instr,
    input  logic [XLEN-1:0]        i_if_cur_pc,
    output logic                   o_if_jmp_stall,
    output logic [XLEN-1:0]        o_if_jmp_pc,
    output logic                   o_if_hazard_stall,
    input  logic                   i_mem_rd_wen,
    input  logic [4:0]             i_mem_rd,
    input  logic                   i_wb_en,
    input  logic [4:0]             i_wb_rd,
    input  logic [XLEN-1:0]        i_wb_data,
    output logic                   o_ex_valid,
    output logic [XLEN-1:0]        o_ex_pc,
    output logic [6:0]             o_ex_opcode,
    output logic [2:0]             o_ex_funct3,
    output logic [6:0]             o_ex_funct7,
    output logic [XLEN-1:0]        o_ex_rs1_data,
    output logic [XLEN-1:0]        o_ex_rs2_data,
    output logic [XLEN-1:0]        o_ex_imm,
    output logic [4:0]             o_ex_rd,
    output logic                   o_ex_rd_wen,
    output logic                   o_ex_illegal
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_wen;
        logic            illegal;
    } ex_bundle_t;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] link_pc;

    assign instr  = i_if_instr[31:0];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j   = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign link_pc = i_if_cur_pc + XLEN'(4);

    // Register file; x0 is never written so it always holds zero.
    logic [XLEN-1:0] regs [REG_NUM];
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_rd != 5'd0)) begin
            regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1];
        if (rs1 == 5'd0) begin
            rs1_data = '0;
        end else if (i_wb_en && (i_wb_rd == rs1)) begin
            rs1_data = i_wb_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2];
        if (rs2 == 5'd0) begin
            rs2_data = '0;
        end else if (i_wb_en && (i_wb_rd == rs2)) begin
            rs2_data = i_wb_data;
        end
    end

    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            has_rd;
    logic            is_jal;
    logic            is_jalr;
    logic            is_branch;
    logic [XLEN-1:0] imm_sel;

    always_comb begin
        legal     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        has_rd    = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        imm_sel   = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal   = 1'b1;
                has_rd  = 1'b1;
                imm_sel = imm_u;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                has_rd  = 1'b1;
                is_jal  = 1'b1;
                imm_sel = link_pc;
            end
            OPC_JALR: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                is_jalr = 1'b1;
                imm_sel = link_pc;
            end
            OPC_BRANCH: begin
                legal     = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                is_branch = 1'b1;
                imm_sel   = imm_b;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                imm_sel = imm_i;
            end
            OPC_STORE: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_sel = imm_s;
            end
            OPC_OP, OPC_OP32: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                has_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    // The all-zero word is a fetch bubble, not an illegal instruction.
    logic illegal;
    assign illegal = !legal && (instr != 32'd0);

    ex_bundle_t ex_q;
    ex_bundle_t ex_d;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    assign rs1_hit = use_rs1 && (rs1 != 5'd0) &&
                     ((ex_q.valid && ex_q.rd_wen && (ex_q.rd == rs1)) ||
                      (i_mem_rd_wen && (i_mem_rd == rs1)));
    assign rs2_hit = use_rs2 && (rs2 != 5'd0) &&
                     ((ex_q.valid && ex_q.rd_wen && (ex_q.rd == rs2)) ||
                      (i_mem_rd_wen && (i_mem_rd == rs2)));
    assign hazard  = !i_rst && legal && (rs1_hit || rs2_hit);

    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_data == rs2_data);
            3'b001:  br_taken = (rs1_data != rs2_data);
            3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_taken = (rs1_data <  rs2_data);
            3'b111:  br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    logic            jmp_taken;
    logic [XLEN-1:0] target_raw;

    assign jmp_taken  = !i_rst && legal && !hazard &&
                        (is_jal || is_jalr || (is_branch && br_taken));
    assign target_raw = is_jalr ? (rs1_data + imm_i)
                                : (i_if_cur_pc + (is_jal ? imm_j : imm_b));

    assign o_if_jmp_stall    = jmp_taken;
    assign o_if_jmp_pc       = jmp_taken ? {target_raw[XLEN-1:2], 2'b00} : '0;
    assign o_if_hazard_stall = hazard;

    always_comb begin
        ex_d = '0;
        if (legal && !hazard) begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = i_if_cur_pc;
            ex_d.opcode   = opcode;
            ex_d.funct3   = funct3;
            ex_d.funct7   = funct7;
            ex_d.rs1_data = rs1_data;
            ex_d.rs2_data = rs2_data;
            ex_d.imm      = imm_sel;
            ex_d.rd       = rd;
            ex_d.rd_wen   = has_rd && (rd != 5'd0);
        end
        ex_d.illegal = illegal;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign o_ex_valid    = ex_q.valid;
    assign o_ex_pc       = ex_q.pc;
    assign o_ex_opcode   = ex_q.opcode;
    assign o_ex_funct3   = ex_q.funct3;
    assign o_ex_funct7   = ex_q.funct7;
    assign o_ex_rs1_data = ex_q.rs1_data;
    assign o_ex_rs2_data = ex_q.rs2_data;
    assign o_ex_imm      = ex_q.imm;
    assign o_ex_rd       = ex_q.rd;
    assign o_ex_rd_wen   = ex_q.rd_wen;
    assign o_ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_nnrv_id.sv
// Directed bench for nnrv_id: stimulus pushes expected EX bundles, a negedge monitor pops and compares them.
module tb_nnrv_id;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_if_instr;
    logic [63:0] i_if_cur_pc;
    logic        o_if_jmp_stall;
    logic [63:0] o_if_jmp_pc;
    logic        o_if_hazard_stall;
    logic        i_mem_rd_wen;
    logic [4:0]  i_mem_rd;
    logic        i_wb_en;
    logic [4:0]  i_wb_rd;
    logic [63:0] i_wb_data;
    logic        o_ex_valid;
    logic [63:0] o_ex_pc;
    logic [6:0]  o_ex_opcode;
    logic [2:0]  o_ex_funct3;
    logic [6:0]  o_ex_funct7;
    logic [63:0] o_ex_rs1_data;
    logic [63:0] o_ex_rs2_data;
    logic [63:0] o_ex_imm;
    logic [4:0]  o_ex_rd;
    logic        o_ex_rd_wen;
    logic        o_ex_illegal;

    always #5 i_clk = ~i_clk;

    nnrv_id dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_instr(i_if_instr), .i_if_cur_pc(i_if_cur_pc),
        .o_if_jmp_stall(o_if_jmp_stall), .o_if_jmp_pc(o_if_jmp_pc),
        .o_if_hazard_stall(o_if_hazard_stall),
        .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd(i_mem_rd),
        .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_opcode(o_ex_opcode),
        .o_ex_funct3(o_ex_funct3), .o_ex_funct7(o_ex_funct7),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_imm(o_ex_imm), .o_ex_rd(o_ex_rd), .o_ex_rd_wen(o_ex_rd_wen),
        .o_ex_illegal(o_ex_illegal)
    );

    localparam logic [31:0] ADDI_X1_X0_5  = 32'h00500093;
    localparam logic [31:0] ADD_X2_X1_X1  = 32'h00108133;
    localparam logic [31:0] ADD_X8_X5_X0  = 32'h00028433;
    localparam logic [31:0] ADD_X7_X0_X0  = 32'h000003B3;
    localparam logic [31:0] BEQ_X3_X4_16  = 32'h00418863;
    localparam logic [31:0] JALR_X1_X2_3  = 32'h003100E7;
    localparam logic [31:0] ILLEGAL_7F    = 32'h0000007F;
    localparam logic [31:0] LUI_X9_ABCDE  = 32'hABCDE4B7;

    typedef struct {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] imm, input logic [4:0] rd, input logic wen);
        exp_t x;
        x.pc = pc; x.op = op; x.f3 = f3; x.f7 = f7; x.r1 = r1; x.r2 = r2;
        x.imm = imm; x.rd = rd; x.wen = wen; x.ill = 1'b0;
        q.push_back(x);
    endtask

    task automatic push_ill();
        exp_t x;
        x.pc = '0; x.op = '0; x.f3 = '0; x.f7 = '0; x.r1 = '0; x.r2 = '0;
        x.imm = '0; x.rd = '0; x.wen = 1'b0; x.ill = 1'b1;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic jmp, input logic [63:0] jpc, input logic haz);
        #1;
        chk({name, "_jmp"},    64'(o_if_jmp_stall),    64'(jmp));
        chk({name, "_jmp_pc"}, o_if_jmp_pc,            jpc);
        chk({name, "_hazard"}, 64'(o_if_hazard_stall), 64'(haz));
    endtask

    always @(negedge i_clk) begin
        if (o_ex_valid === 1'b1 || o_ex_illegal === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_ex_output", 64'(o_ex_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("ex_valid",   64'(o_ex_valid),   64'(!e.ill));
                chk("ex_illegal", 64'(o_ex_illegal), 64'(e.ill));
                if (!e.ill) begin
                    chk("ex_pc",     o_ex_pc,             e.pc);
                    chk("ex_opcode", 64'(o_ex_opcode),    64'(e.op));
                    chk("ex_funct3", 64'(o_ex_funct3),    64'(e.f3));
                    chk("ex_funct7", 64'(o_ex_funct7),    64'(e.f7));
                    chk("ex_rs1",    o_ex_rs1_data,       e.r1);
                    chk("ex_rs2",    o_ex_rs2_data,       e.r2);
                    chk("ex_imm",    o_ex_imm,            e.imm);
                    chk("ex_rd",     64'(o_ex_rd),        64'(e.rd));
                    chk("ex_rd_wen", 64'(o_ex_rd_wen),    64'(e.wen));
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_if_instr = '0; i_if_cur_pc = '0;
        i_mem_rd_wen = 1'b0; i_mem_rd = '0;
        i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // ADDI x1,x0,5; rs2 field names x5, which WB writes this same cycle
        i_if_instr = ADDI_X1_X0_5; i_if_cur_pc = 64'h0;
        i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 64'h55;
        chk_fetch("addi", 1'b0, 64'h0, 1'b0);
        push(64'h0, 7'h13, 3'd0, 7'd0, 64'h0, 64'h55, 64'd5, 5'd1, 1'b1);
        step();

        // Reset with a JALR present: fetch-facing outputs must stay low
        i_rst = 1'b1; i_wb_en = 1'b0;
        i_if_instr = JALR_X1_X2_3; i_if_cur_pc = 64'h40;
        chk_fetch("rst", 1'b0, 64'h0, 1'b0);
        step();
        chk("rst_ex_valid",  64'(o_ex_valid),   64'h0);
        chk("rst_ex_pc",     o_ex_pc,           64'h0);
        chk("rst_ex_opcode", 64'(o_ex_opcode),  64'h0);
        chk("rst_ex_imm",    o_ex_imm,          64'h0);
        chk("rst_ex_rs2",    o_ex_rs2_data,     64'h0);
        chk("rst_ex_rd",     64'(o_ex_rd),      64'h0);
        chk("rst_ex_rd_wen", 64'(o_ex_rd_wen),  64'h0);
        chk("rst_ex_ill",    64'(o_ex_illegal), 64'h0);
        step();
        i_rst = 1'b0;

        // x5 was cleared by reset
        i_if_instr = ADD_X8_X5_X0; i_if_cur_pc = 64'h4;
        push(64'h4, 7'h33, 3'd0, 7'd0, 64'h0, 64'h0, 64'h0, 5'd8, 1'b1);
        step();

        // RAW dependency: ADDI x1 then ADD x2,x1,x1 stalls two cycles
        i_if_instr = ADDI_X1_X0_5; i_if_cur_pc = 64'h8;
        chk_fetch("dep_producer", 1'b0, 64'h0, 1'b0);
        push(64'h8, 7'h13, 3'd0, 7'd0, 64'h0, 64'h0, 64'd5, 5'd1, 1'b1);
        step();
        i_if_instr = ADD_X2_X1_X1; i_if_cur_pc = 64'hC;
        i_mem_rd_wen = 1'b1; i_mem_rd = 5'd8;
        chk_fetch("dep_stall1", 1'b0, 64'h0, 1'b1);
        step();
        chk("dep_bubble1", 64'(o_ex_valid), 64'h0);
        i_mem_rd = 5'd1; i_wb_en = 1'b1; i_wb_rd = 5'd8; i_wb_data = 64'h0;
        chk_fetch("dep_stall2", 1'b0, 64'h0, 1'b1);
        step();
        chk("dep_bubble2", 64'(o_ex_valid), 64'h0);
        i_mem_rd_wen = 1'b0; i_mem_rd = 5'd0; i_wb_rd = 5'd1; i_wb_data = 64'd5;
        chk_fetch("dep_issue", 1'b0, 64'h0, 1'b0);
        push(64'hC, 7'h33, 3'd0, 7'd0, 64'd5, 64'd5, 64'h0, 5'd2, 1'b1);
        step();

        // Preload x3=7, x4=7, x2=0x200
        i_if_instr = 32'h0;
        i_wb_rd = 5'd3; i_wb_data = 64'd7;    step();
        i_wb_rd = 5'd4; i_wb_data = 64'd7;    step();
        i_wb_rd = 5'd2; i_wb_data = 64'h200;  step();
        i_wb_en = 1'b0;

        // Taken BEQ at 0x100 -> 0x110
        i_if_instr = BEQ_X3_X4_16; i_if_cur_pc = 64'h100;
        chk_fetch("beq_taken", 1'b1, 64'h110, 1'b0);
        push(64'h100, 7'h63, 3'd0, 7'd0, 64'd7, 64'd7, 64'd16, 5'd16, 1'b0);
        step();

        i_if_instr = 32'h0; i_wb_en = 1'b1; i_wb_rd = 5'd4; i_wb_data = 64'd8;
        step();
        i_wb_en = 1'b0;

        // Not-taken BEQ
        i_if_instr = BEQ_X3_X4_16; i_if_cur_pc = 64'h104;
        chk_fetch("beq_not_taken", 1'b0, 64'h0, 1'b0);
        push(64'h104, 7'h63, 3'd0, 7'd0, 64'd7, 64'd8, 64'd16, 5'd16, 1'b0);
        step();

        // JALR x1,x2,3: 0x203 with low bits cleared; imm carries link pc+4
        i_if_instr = JALR_X1_X2_3; i_if_cur_pc = 64'h40;
        chk_fetch("jalr", 1'b1, 64'h200, 1'b0);
        push(64'h40, 7'h67, 3'd0, 7'd0, 64'h200, 64'd7, 64'h44, 5'd1, 1'b1);
        step();

        i_if_instr = ILLEGAL_7F; i_if_cur_pc = 64'h44;
        chk_fetch("illegal", 1'b0, 64'h0, 1'b0);
        push_ill();
        step();

        // Writes to x0 are dropped, including the write-through path
        i_if_instr = ADD_X7_X0_X0; i_if_cur_pc = 64'h48;
        i_wb_en = 1'b1; i_wb_rd = 5'd0; i_wb_data = 64'hDEAD;
        push(64'h48, 7'h33, 3'd0, 7'd0, 64'h0, 64'h0, 64'h0, 5'd7, 1'b1);
        step();
        i_wb_en = 1'b0;
        i_if_cur_pc = 64'h4C;
        push(64'h4C, 7'h33, 3'd0, 7'd0, 64'h0, 64'h0, 64'h0, 5'd7, 1'b1);
        step();

        // LUI with negative upper immediate
        i_if_instr = LUI_X9_ABCDE; i_if_cur_pc = 64'h50;
        chk_fetch("lui", 1'b0, 64'h0, 1'b0);
        push(64'h50, 7'h37, 3'd6, 7'h55, 64'h0, 64'h0, 64'hFFFF_FFFF_ABCD_E000, 5'd9, 1'b1);
        step();
        i_if_instr = 32'h0;

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            step();
        end
        chk("scoreboard_drained", 64'(q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
